// File: rtl/avst_packets_to_bytes.sv
// Avalon-ST packet-to-byte-stream encoder.
// Each accepted beat becomes a byte sequence: optional channel marker and
// channel byte, optional SOP and EOP markers, then the data byte. The
// channel byte and the data byte are escaped when they collide with a
// marker value. The source side is fully registered. The sink ready depends
// only on the source state and out_ready, never on in_*.
module avst_packets_to_bytes (
    input  logic       clk,
    input  logic       reset,
    output logic       in_ready,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [7:0] in_channel,
    input  logic       in_startofpacket,
    input  logic       in_endofpacket,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data
);

    localparam logic [7:0] SOP_BYTE  = 8'h7A;
    localparam logic [7:0] EOP_BYTE  = 8'h7B;
    localparam logic [7:0] CHAN_BYTE = 8'h7C;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    // The state names the byte that is currently presented on out_data.
    typedef enum logic [2:0] {
        IDLE,
        CH_MARK,
        CH_ESC,
        CH_BYTE,
        SOP_MARK,
        EOP_MARK,
        DATA_ESC,
        DATA
    } state_t;

    state_t     r_state;
    logic       r_out_valid;
    logic [7:0] r_out_data;

    // Holding registers for the beat being serialised.
    logic [7:0] r_data;
    logic [7:0] r_channel;
    logic       r_sop;
    logic       r_eop;

    // Channel most recently sent downstream. The flag is clear until the
    // first channel byte has left the block.
    logic       r_chan_valid;
    logic [7:0] r_last_chan;

    logic       w_accept;
    logic       w_fire;
    logic       w_last_byte;
    logic       w_chan_changed;
    state_t     w_start_state;
    state_t     w_cont_state;

    // True for byte values that collide with one of the four markers.
    function automatic logic needs_esc(input logic [7:0] b);
        return (b >= SOP_BYTE) && (b <= ESC_BYTE);
    endfunction

    // Next byte of a sequence after 'cur'. From IDLE this returns the first
    // byte of a new sequence. Stages the beat does not need are skipped.
    function automatic state_t next_state(
        input state_t     cur,
        input logic       chg,
        input logic [7:0] chan,
        input logic       sop,
        input logic       eop,
        input logic [7:0] data
    );
        state_t data_start;
        state_t eop_start;
        state_t sop_start;
        state_t chan_start;
        state_t ns;
        data_start = needs_esc(data) ? DATA_ESC : DATA;
        eop_start  = eop ? EOP_MARK : data_start;
        sop_start  = sop ? SOP_MARK : eop_start;
        chan_start = chg ? CH_MARK  : sop_start;
        case (cur)
            IDLE:     ns = chan_start;
            CH_MARK:  ns = needs_esc(chan) ? CH_ESC : CH_BYTE;
            CH_ESC:   ns = CH_BYTE;
            CH_BYTE:  ns = sop_start;
            SOP_MARK: ns = eop_start;
            EOP_MARK: ns = data_start;
            DATA_ESC: ns = DATA;
            default:  ns = IDLE;
        endcase
        return ns;
    endfunction

    // Byte value presented while in a given state.
    function automatic logic [7:0] byte_for(
        input state_t     st,
        input logic [7:0] chan,
        input logic [7:0] data
    );
        logic [7:0] b;
        case (st)
            CH_MARK:  b = CHAN_BYTE;
            CH_ESC:   b = ESC_BYTE;
            CH_BYTE:  b = needs_esc(chan) ? (chan ^ ESC_XOR) : chan;
            SOP_MARK: b = SOP_BYTE;
            EOP_MARK: b = EOP_BYTE;
            DATA_ESC: b = ESC_BYTE;
            DATA:     b = needs_esc(data) ? (data ^ ESC_XOR) : data;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    // Handshake qualifiers and the candidate next states.
    // The data byte is always the last byte of a sequence. A new beat can
    // therefore be taken while the block is idle, or in the same cycle that
    // the data byte leaves.
    always_comb begin
        w_fire         = r_out_valid && out_ready;
        w_last_byte    = (r_state == DATA);
        in_ready       = !r_out_valid || (out_ready && w_last_byte);
        w_accept       = in_valid && in_ready;
        w_chan_changed = !r_chan_valid || (in_channel != r_last_chan);
        w_start_state  = next_state(IDLE, w_chan_changed, in_channel,
                                    in_startofpacket, in_endofpacket, in_data);
        w_cont_state   = next_state(r_state, 1'b0, r_channel,
                                    r_sop, r_eop, r_data);
    end

    // Sequencer: captures beats, steps through their bytes on each
    // downstream transfer, and tracks the last channel sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_data       <= 8'h00;
            r_channel    <= 8'h00;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_chan_valid <= 1'b0;
            r_last_chan  <= 8'h00;
        end else begin
            // A channel counts as sent only once its byte has been taken.
            if (w_fire && (r_state == CH_BYTE)) begin
                r_last_chan  <= r_channel;
                r_chan_valid <= 1'b1;
            end

            if (w_accept) begin
                r_data      <= in_data;
                r_channel   <= in_channel;
                r_sop       <= in_startofpacket;
                r_eop       <= in_endofpacket;
                r_state     <= w_start_state;
                r_out_valid <= 1'b1;
                r_out_data  <= byte_for(w_start_state, in_channel, in_data);
            end else if (w_fire) begin
                if (w_last_byte) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end else begin
                    r_state    <= w_cont_state;
                    r_out_data <= byte_for(w_cont_state, r_channel, r_data);
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_avst_packets_to_bytes.sv
// Testbench for avst_packets_to_bytes: directed and randomized scenarios
// checked against a byte-level reference encoder.
`timescale 1ns/1ps
module tb_avst_packets_to_bytes;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_ready;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_channel = 8'h00;
    logic       in_startofpacket = 1'b0;
    logic       in_endofpacket = 1'b0;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Reference model: last channel put on the wire since reset.
    logic       m_have_ch = 1'b0;
    logic [7:0] m_last_ch = 8'h00;

    int         stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rnd_stop = 1'b0;
    logic [7:0] rnd_ch = 8'h00;
    int         b2b_run = 0;
    int         b2b_max = 0;

    avst_packets_to_bytes dut (
        .clk              (clk),
        .reset            (reset),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    always #5 clk = ~clk;

    // Collect transferred bytes and watch that stalled outputs hold.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || (out_data !== prev_data)))
                stall_viol++;
            if (out_valid && out_ready)
                got_q.push_back(out_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic void push_esc(input logic [7:0] b);
        if (b >= 8'h7A && b <= 8'h7D) begin
            exp_q.push_back(8'h7D);
            exp_q.push_back(b ^ 8'h20);
        end else begin
            exp_q.push_back(b);
        end
    endfunction

    // Encode one beat the way the wire format defines it.
    function automatic void model_beat(input logic [7:0] ch, input logic s,
                                       input logic e, input logic [7:0] d);
        if (!m_have_ch || ch != m_last_ch) begin
            exp_q.push_back(8'h7C);
            push_esc(ch);
            m_have_ch = 1'b1;
            m_last_ch = ch;
        end
        if (s) exp_q.push_back(8'h7A);
        if (e) exp_q.push_back(8'h7B);
        push_esc(d);
    endfunction

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic send_beat(input logic [7:0] ch, input logic s,
                             input logic e, input logic [7:0] d);
        int waited;
        bit done;
        waited = 0;
        done = 1'b0;
        in_valid = 1'b1;
        in_channel = ch;
        in_startofpacket = s;
        in_endofpacket = e;
        in_data = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
                model_beat(ch, s, e, d);
            end else begin
                @(posedge clk); #1;
                waited++;
                if (waited > 500) begin
                    checks++;
                    failures++;
                    $display("FAIL send_timeout in_ready got 0 for 500 cycles, required 1");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait until the expected byte count has left and the source is idle.
    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while (!((got_q.size() >= exp_q.size()) && !out_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got %0d bytes, required %0d", got_q.size(), exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got %b required 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data got 0x%02h required 0x00", out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_have_ch = 1'b0;
        m_last_ch = 8'h00;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [7:0] e1 [4];
        logic [7:0] e2 [3];
        logic [3:0] rdy_exp;
        e1 = '{8'h7C, 8'h00, 8'h7A, 8'h41};
        e2 = '{8'h42, 8'h7B, 8'h43};
        rdy_exp = 4'b1000;
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        send_beat(8'h00, 1'b1, 1'b0, 8'h41);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7C) begin
            failures++;
            $display("FAIL first_byte_latency got valid=%b data=0x%02h required valid=1 data=0x7C", out_valid, out_data);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== rdy_exp[k]) begin
                failures++;
                $display("FAIL in_ready_seq[%0d] got %b required %b", k, in_ready, rdy_exp[k]);
            end
            @(posedge clk); #1;
        end
        wait_drain();
        checks++;
        if (got_q.size() != 4) begin
            failures++;
            $display("FAIL basic1_len got %0d required 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== e1[i]) begin
                failures++;
                $display("FAIL basic1_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], e1[i]);
            end
        end
        $display("beat ch=00 sop data=41 -> %0d bytes", got_q.size());

        got_q.delete();
        exp_q.delete();
        send_beat(8'h00, 1'b0, 1'b0, 8'h42);
        send_beat(8'h00, 1'b0, 1'b1, 8'h43);
        wait_drain();
        checks++;
        if (got_q.size() != 3) begin
            failures++;
            $display("FAIL basic2_len got %0d required 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== e2[i]) begin
                failures++;
                $display("FAIL basic2_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], e2[i]);
            end
        end
        $display("beats 42,43+eop -> %0d bytes", got_q.size());
    endtask

    task automatic test_escape();
        logic [7:0] e3 [7];
        e3 = '{8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h7B, 8'h7D, 8'h5A};
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        send_beat(8'h7D, 1'b1, 1'b1, 8'h7A);
        wait_drain();
        checks++;
        if (got_q.size() != 7) begin
            failures++;
            $display("FAIL escape_len got %0d required 7", got_q.size());
        end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== e3[i]) begin
                failures++;
                $display("FAIL escape_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], e3[i]);
            end
        end
        $display("beat ch=7D sop eop data=7A -> %0d bytes", got_q.size());
    endtask

    task automatic test_random();
        got_q.delete();
        exp_q.delete();
        stall_viol = 0;
        rnd_stop = 1'b0;
        rnd_ch = m_last_ch;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] d;
                    logic s;
                    logic e;
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 6))
                            0: rnd_ch = 8'h00;
                            1: rnd_ch = 8'h05;
                            2: rnd_ch = 8'h7A;
                            3: rnd_ch = 8'h7B;
                            4: rnd_ch = 8'h7C;
                            5: rnd_ch = 8'h7D;
                            default: rnd_ch = 8'($urandom);
                        endcase
                    end
                    if ($urandom_range(0, 3) == 0)
                        d = 8'(8'h7A + 8'($urandom_range(0, 3)));
                    else
                        d = 8'($urandom);
                    s = ($urandom_range(0, 3) == 0);
                    e = ($urandom_range(0, 3) == 0);
                    send_beat(rnd_ch, s, e, d);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_stop = 1'b1;
            end
            begin
                while (!rnd_stop) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_len got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], exp_q[i]);
                break;
            end
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d unstable stalled cycles required 0", stall_viol);
        end
        $display("random 1000 beats -> %0d bytes", got_q.size());
    endtask

    task automatic test_reset_midseq();
        logic [7:0] e4 [3];
        e4 = '{8'h7C, 8'h05, 8'h33};
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        send_beat(m_last_ch, 1'b1, 1'b0, 8'h11);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7A) begin
            failures++;
            $display("FAIL pending_sop got valid=%b data=0x%02h required valid=1 data=0x7A", out_valid, out_data);
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h7A) begin
            failures++;
            $display("FAIL stalled_hold got valid=%b data=0x%02h required valid=1 data=0x7A", out_valid, out_data);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_valid got %b required 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++;
            $display("FAIL async_reset_data got 0x%02h required 0x00", out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_have_ch = 1'b0;
        m_last_ch = 8'h00;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_beat(8'h05, 1'b0, 1'b0, 8'h33);
        wait_drain();
        checks++;
        if (got_q.size() != 3) begin
            failures++;
            $display("FAIL post_reset_len got %0d required 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== e4[i]) begin
                failures++;
                $display("FAIL post_reset_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], e4[i]);
            end
        end
        $display("reset mid-sequence then ch=05 data=33 -> %0d bytes", got_q.size());
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        b2b_run = 0;
        b2b_max = 0;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send_beat(8'h05, 1'b0, 1'b0, 8'(i));
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (out_valid) begin
                        b2b_run++;
                        if (b2b_run > b2b_max) b2b_max = b2b_run;
                    end else begin
                        b2b_run = 0;
                    end
                end
            end
        join
        wait_drain();
        checks++;
        if (b2b_max != 16) begin
            failures++;
            $display("FAIL b2b_run got %0d consecutive valid cycles required 16", b2b_max);
        end
        checks++;
        if (got_q.size() != 16) begin
            failures++;
            $display("FAIL b2b_len got %0d required 16", got_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(i)) begin
                failures++;
                $display("FAIL b2b_byte[%0d] got 0x%02h required 0x%02h", i, got_q[i], 8'(i));
            end
        end
        $display("back-to-back 16 beats -> run of %0d valid cycles", b2b_max);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_escape();
        test_random();
        test_reset_midseq();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
